join_any_rx: RTL and testbench

Serial receive monitor for the UART block's transmit line. It oversamples `sdata` at 16× the bit rate, using a tick derived from the `divisor` setting. Each character is decoded according to the word format in `lcr`. After each character it presents the data byte with parity and framing error flags. Start bits that turn out to be glitches are detected and dropped. The block sits beside the UART as a checker/scoreboard feed.

---
 rtl/join_any_rx.sv | 183 ++++++++++++++++++
 tb/tb_join_any_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/join_any_rx.sv
// join_any_rx: 16x oversampling serial receive monitor.
// Decodes one character per frame using the word format in lcr, then reports
// the data byte with parity/framing error flags. Glitched start bits are dropped.
module join_any_rx (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic        sdata,
  input  logic [15:0] divisor,
  input  logic [7:0]  lcr,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        pe,
  output logic        fe,
  output logic        sbe
);

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned TCNT_W = 5;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 3;

  typedef enum logic [2:0] {
    WARMUP,
    IDLE,
    START,
    DATA,
    PARITY,
    STOP_ALIGN,
    STOP
  } state_t;

  logic [DIV_W-1:0]  div_eff;
  logic [DIV_W-1:0]  div_cnt;
  logic              half_clk;
  logic              tick;

  state_t            state;
  logic [TCNT_W-1:0] tcnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [IDX_W-1:0]  last_idx;
  logic [DATA_W-1:0] shreg;
  logic              pe_acc;
  logic              fe_acc;
  logic              par_exp;
  logic              lcr_unused;

  // Divisor of zero behaves as one
  assign div_eff = (divisor == DIV_W'(0)) ? DIV_W'(1) : divisor;

  // Index of the final data bit: word length minus one
  assign last_idx = IDX_W'(4) + IDX_W'(lcr[1:0]);

  // Expected parity bit over the received word (upper shreg bits are zero)
  assign par_exp = lcr[5] ? ~lcr[4] : (lcr[4] ? ^shreg : ~(^shreg));

  // Bits of lcr that do not affect reception
  assign lcr_unused = ^{lcr[7:6], lcr[2]};

  // Tick generator: half-clock toggles every div_eff cycles, tick on its rise
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      half_clk <= 1'b0;
      tick     <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (div_cnt >= div_eff - DIV_W'(1)) begin
        div_cnt  <= '0;
        half_clk <= ~half_clk;
        tick     <= ~half_clk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // Receive FSM: all state advances on ticks, output pulses last one sclk
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state    <= WARMUP;
      tcnt     <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      pe_acc   <= 1'b0;
      fe_acc   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      pe       <= 1'b0;
      fe       <= 1'b0;
      sbe      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      sbe      <= 1'b0;
      if (tick) begin
        case (state)
          WARMUP: begin
            if (tcnt == TCNT_W'(2)) begin
              state <= IDLE;
              tcnt  <= '0;
            end else begin
              tcnt <= tcnt + TCNT_W'(1);
            end
          end
          IDLE: begin
            if (!sdata) begin
              state  <= START;
              tcnt   <= '0;
              shreg  <= '0;
              pe_acc <= 1'b0;
              fe_acc <= 1'b0;
            end
          end
          START: begin
            // tcnt holds (current tick - 1); ticks 1..8 must stay low
            if (tcnt < TCNT_W'(8) && sdata) begin
              sbe   <= 1'b1;
              state <= IDLE;
              tcnt  <= '0;
            end else if (tcnt == TCNT_W'(22)) begin
              shreg[0] <= sdata;
              bit_idx  <= IDX_W'(1);
              tcnt     <= '0;
              state    <= DATA;
            end else begin
              tcnt <= tcnt + TCNT_W'(1);
            end
          end
          DATA: begin
            if (tcnt == TCNT_W'(15)) begin
              shreg[bit_idx] <= sdata;
              tcnt           <= '0;
              if (bit_idx == last_idx) begin
                state <= lcr[3] ? PARITY : STOP_ALIGN;
              end else begin
                bit_idx <= bit_idx + IDX_W'(1);
              end
            end else begin
              tcnt <= tcnt + TCNT_W'(1);
            end
          end
          PARITY: begin
            if (tcnt == TCNT_W'(15)) begin
              pe_acc <= (sdata != par_exp);
              tcnt   <= '0;
              state  <= STOP_ALIGN;
            end else begin
              tcnt <= tcnt + TCNT_W'(1);
            end
          end
          STOP_ALIGN: begin
            if (tcnt == TCNT_W'(7)) begin
              tcnt  <= '0;
              state <= STOP;
            end else begin
              tcnt <= tcnt + TCNT_W'(1);
            end
          end
          STOP: begin
            if (!sdata) begin
              fe_acc <= 1'b1;
            end
            if (tcnt == TCNT_W'(15)) begin
              rx_data  <= shreg;
              pe       <= pe_acc;
              fe       <= fe_acc | ~sdata;
              rx_valid <= 1'b1;
              shreg    <= '0;
              tcnt     <= '0;
              state    <= IDLE;
            end else begin
              tcnt <= tcnt + TCNT_W'(1);
            end
          end
          default: begin
            state <= WARMUP;
            tcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_join_any_rx.sv
// tb_join_any_rx: directed and randomized frames against a frame-level model.
module tb_join_any_rx;

  logic        sclk;
  logic        rst_n;
  logic        sdata;
  logic [15:0] divisor;
  logic [7:0]  lcr;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        pe;
  logic        fe;
  logic        sbe;

  int n_vec  = 0;
  int n_err  = 0;
  int n_valid = 0;
  int n_sbe  = 0;
  int n_both = 0;
  int cyc    = 0;
  logic [7:0] cap_data = '0;
  logic       cap_pe   = 1'b0;
  logic       cap_fe   = 1'b0;
  int         cap_cyc  = 0;

  join_any_rx dut (
    .sclk     (sclk),
    .rst_n    (rst_n),
    .sdata    (sdata),
    .divisor  (divisor),
    .lcr      (lcr),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .pe       (pe),
    .fe       (fe),
    .sbe      (sbe)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Output monitor, sampled on the falling edge
  always @(negedge sclk) begin
    cyc = cyc + 1;
    if (rx_valid) begin
      n_valid  = n_valid + 1;
      cap_data = rx_data;
      cap_pe   = pe;
      cap_fe   = fe;
      cap_cyc  = cyc;
    end
    if (sbe) n_sbe = n_sbe + 1;
    if (sbe && rx_valid) n_both = n_both + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int unsigned n);
    repeat (n) @(negedge sclk);
  endtask

  // Drive one frame and compare the reported character with the model
  task automatic send_frame(input logic [7:0] data, input logic [7:0] l,
                            input logic pbit, input logic sbit, input int unsigned d);
    int unsigned dv;
    int unsigned bp;
    int unsigned wl;
    int unsigned final_tick;
    int unsigned lat;
    int unsigned lo;
    int unsigned hi;
    int v0;
    int s0;
    int t0;
    logic [7:0] mask;
    logic [7:0] exp_data;
    logic       par_exp;
    logic       pe_exp;
    logic       fe_exp;
    dv = (d == 0) ? 1 : d;
    bp = 32 * dv;
    wl = 5 + int'(l[1:0]);
    mask = 8'((1 << wl) - 1);
    exp_data = data & mask;
    if (l[5])      par_exp = ~l[4];
    else if (l[4]) par_exp = 1'($countones(exp_data) % 2);
    else           par_exp = ~1'($countones(exp_data) % 2);
    pe_exp = l[3] ? (pbit != par_exp) : 1'b0;
    fe_exp = ~sbit;
    final_tick = 23 + 16 * (wl - 1) + (l[3] ? 16 : 0) + 24;
    lo = final_tick * 2 * dv - 1;
    hi = final_tick * 2 * dv + 2 * dv + 4;
    divisor = 16'(d);
    lcr = l;
    sdata = 1'b1;
    hold(bp);
    v0 = n_valid;
    s0 = n_sbe;
    t0 = cyc;
    sdata = 1'b0;
    hold(bp);
    for (int i = 0; i < int'(wl); i++) begin
      sdata = data[i];
      hold(bp);
    end
    if (l[3]) begin
      sdata = pbit;
      hold(bp);
    end
    sdata = sbit;
    hold(bp);
    sdata = 1'b1;
    hold(bp);
    chk("valid_count", 32'(n_valid - v0), 32'd1);
    chk("no_sbe", 32'(n_sbe - s0), 32'd0);
    chk("rx_data", 32'(cap_data), 32'(exp_data));
    chk("pe", 32'(cap_pe), 32'(pe_exp));
    chk("fe", 32'(cap_fe), 32'(fe_exp));
    chk("pe_held", 32'(pe), 32'(pe_exp));
    chk("fe_held", 32'(fe), 32'(fe_exp));
    lat = int'(cap_cyc - t0);
    chk("latency_window", 32'((lat >= lo) && (lat <= hi)), 32'd1);
  endtask

  initial begin
    int v0;
    int s0;
    rst_n   = 1'b0;
    sdata   = 1'b1;
    divisor = 16'd1;
    lcr     = 8'h03;
    hold(4);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_pe", 32'(pe), 32'd0);
    chk("rst_fe", 32'(fe), 32'd0);
    chk("rst_sbe", 32'(sbe), 32'd0);
    rst_n = 1'b1;
    hold(20);

    // 8N1 clean
    send_frame(8'hA5, 8'h03, 1'b0, 1'b1, 1);
    chk("8n1_data", 32'(cap_data), 32'hA5);
    // 5-bit even parity, wrong parity bit
    send_frame(8'h15, 8'h18, 1'b0, 1'b1, 1);
    chk("5e_pe", 32'(cap_pe), 32'd1);
    // 7-bit odd parity, correct parity bit
    send_frame(8'h41, 8'h0A, 1'b1, 1'b1, 1);
    chk("7o_pe", 32'(cap_pe), 32'd0);
    chk("7o_data", 32'(cap_data), 32'h41);
    // Framing error
    send_frame(8'h3C, 8'h03, 1'b0, 1'b0, 1);
    chk("fe_flag", 32'(cap_fe), 32'd1);

    // False start: low for 4 ticks then high
    divisor = 16'd1;
    lcr = 8'h03;
    v0 = n_valid;
    s0 = n_sbe;
    sdata = 1'b0;
    hold(8);
    sdata = 1'b1;
    hold(64);
    chk("false_start_sbe", 32'(n_sbe - s0), 32'd1);
    chk("false_start_no_valid", 32'(n_valid - v0), 32'd0);
    send_frame(8'h55, 8'h03, 1'b0, 1'b1, 1);

    // Reset during data bit 3 (fe was left high by an earlier error frame)
    send_frame(8'h00, 8'h03, 1'b0, 1'b0, 1);
    v0 = n_valid;
    s0 = n_sbe;
    sdata = 1'b0;
    hold(32);
    sdata = 1'b1; hold(32);
    sdata = 1'b0; hold(32);
    sdata = 1'b0; hold(32);
    sdata = 1'b0; hold(16);
    rst_n = 1'b0;
    sdata = 1'b1;
    hold(4);
    chk("midrst_fe", 32'(fe), 32'd0);
    chk("midrst_data", 32'(rx_data), 32'd0);
    rst_n = 1'b1;
    hold(32 * 12);
    chk("midrst_no_valid", 32'(n_valid - v0), 32'd0);
    chk("midrst_no_sbe", 32'(n_sbe - s0), 32'd0);
    chk("midrst_outs", 32'({rx_data, pe, fe, rx_valid, sbe}), 32'd0);
    send_frame(8'h81, 8'h03, 1'b0, 1'b1, 1);
    chk("after_rst_data", 32'(cap_data), 32'h81);

    // Randomized frames over formats and divisors (0 behaves as 1)
    for (int k = 0; k < 20; k++) begin
      logic [7:0] rd;
      logic [7:0] rl;
      logic       rp;
      logic       rs;
      int unsigned rdv;
      rd  = 8'($urandom);
      rl  = 8'($urandom);
      rp  = 1'($urandom);
      rs  = ($urandom_range(0, 3) != 0);
      rdv = $urandom_range(0, 3);
      send_frame(rd, rl, rp, rs, rdv);
    end

    chk("sbe_with_valid", 32'(n_both), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
